// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// mult/multu and div/divu run for a fixed number of cycles on operands
// latched at acceptance. mthi/mtlo write HI/LO in a single edge.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    md_op_t        op_q, op_next;
    logic [31:0]   a_q, a_next;
    logic [31:0]   b_q, b_next;
    logic [31:0]   hi_q, hi_next;
    logic [31:0]   lo_q, lo_next;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [31:0]        res_hi, res_lo;
    logic               res_write;

    assign Busy = (state == S_RUN);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

    // Result datapath from the latched operands. Signed division works on
    // magnitudes, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    always_comb begin
        prod_s    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u    = {32'd0, a_q} * {32'd0, b_q};
        a_neg     = (op_q == OP_DIV) && a_q[31];
        b_neg     = (op_q == OP_DIV) && b_q[31];
        a_mag     = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag     = b_neg ? (~b_q + 32'd1) : b_q;
        q_mag     = '0;
        r_mag     = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
        res_hi    = '0;
        res_lo    = '0;
        res_write = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_write = 1'b1;
            end
            OP_MULTU: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_write = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = rem;
                res_lo    = quot;
                res_write = (b_q != '0);
            end
            default: ;
        endcase
    end

    // Next-state: accept/launch when idle, count down and retire when running.
    always_comb begin
        state_next = state;
        count_next = count;
        op_next    = op_q;
        a_next     = a_q;
        b_next     = b_q;
        hi_next    = hi_q;
        lo_next    = lo_q;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            op_next    = md_op_t'(MDOp);
                            a_next     = A;
                            b_next     = B;
                            count_next = CW'(MULT_CYCLES);
                            state_next = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_next    = md_op_t'(MDOp);
                            a_next     = A;
                            b_next     = B;
                            count_next = CW'(DIV_CYCLES);
                            state_next = S_RUN;
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (count == CW'(1)) begin
                    count_next = '0;
                    state_next = S_IDLE;
                    if (res_write) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end else begin
                    count_next = count - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, counter, operand and HI/LO registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            count <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            op_q  <= op_next;
            a_q   <= a_next;
            b_q   <= b_next;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the Busy duration in cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the Busy duration in cycles for div/divu.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  EX-stage request to launch the operation in MDOp.
REQ-006 MDOp  in  3  operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
REQ-007 A  in  32  rs operand (dividend, multiplicand, or mthi/mtlo source).
REQ-008 B  in  32  rt operand (divisor or multiplier).
REQ-009 Busy  out  1  operation in progress; hazard unit stalls on Start|Busy.
REQ-010 Hi  out  32  architectural HI register, feeds the EX/MEM stage Hi input.
REQ-011 Lo  out  32  architectural LO register, feeds the EX/MEM stage Lo input.

Function
REQ-012 Hi, Lo and Busy SHALL be driven directly from registers, with no combinational path from any input.
REQ-013 Accept: at a rising edge with Start=1, Busy=0 and MDOp in {000..011}, the block SHALL latch A, B and MDOp, load the down-counter with MULT_CYCLES or DIV_CYCLES, and set Busy=1.
REQ-014 While Busy=1, each rising edge SHALL decrement the counter.
REQ-015 At the edge where the counter equals 1, the block SHALL write the result to Hi/Lo and clear Busy, so Busy is high for exactly N cycles.
REQ-016 New Hi/Lo values SHALL be visible in the same cycle that Busy first reads 0.
REQ-017 mult SHALL compute the signed 64-bit product; multu SHALL compute the unsigned 64-bit product; both SHALL write Hi=product[63:32] and Lo=product[31:0].
REQ-018 div/divu SHALL write Lo=quotient and Hi=remainder.
REQ-019 Signed div SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give Lo=0x80000000 and Hi=0x00000000.
REQ-021 Divide by zero (B=0) SHALL still hold Busy for DIV_CYCLES cycles and SHALL leave Hi and Lo unchanged at completion.
REQ-022 mthi/mtlo: at a rising edge with Start=1 and Busy=0, the block SHALL write A into Hi (100) or Lo (101) in that edge and SHALL NOT assert Busy.
REQ-023 Start=1 while Busy=1 SHALL be ignored; the in-flight operation and its operands SHALL be unaffected.
REQ-024 Start=1 with a reserved MDOp (110/111) SHALL be ignored, with no state change.
REQ-025 Operand changes on A/B after acceptance SHALL NOT affect the in-flight result.
REQ-026 Back-to-back: Start=1 in the cycle where Busy first reads 0 SHALL be accepted at that edge, with no idle cycle required.
REQ-027 With Start=0 and Busy=0, Hi and Lo SHALL hold their values indefinitely.

Reset
REQ-028 Reset=1 SHALL immediately, without waiting for Clk, force Hi=0, Lo=0, Busy=0, counter=0 and latched operands=0.
REQ-029 Reset asserted during an operation SHALL discard that operation, with no later write to Hi/Lo.
REQ-030 Start sampled on the first rising edge after Reset deasserts SHALL be accepted normally.

Verification
REQ-031 mult: A=0xFFFFFFFE (-2), B=3, Start 1 cycle -> Busy high for exactly 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
REQ-032 multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-033 div: A=0xFFFFFFF9 (-7), B=2 -> Busy high for exactly 10 cycles, then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-034 divu with B=0 after Hi=0x11111111 and Lo=0x22222222 -> Busy high 10 cycles, then Hi and Lo unchanged; a div issued while Busy in that window is ignored.
REQ-035 mthi with A=0xDEADBEEF, then mtlo with A=0x12345678 on consecutive cycles -> Hi=0xDEADBEEF and Lo=0x12345678 after the second edge, Busy never asserted.
REQ-036 Start a div, assert Reset asynchronously mid-cycle at count 4 -> Hi=Lo=0 and Busy=0 before the next edge; no write after release; a mult started on the first edge after release completes in 5 cycles.
